// File: rtl/b_pkg.sv
// Shared types for the b-unit serial receive path.
package b_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DATA  = 2'd1,
      PAR   = 2'd2,
      DRAIN = 2'd3
   } b_state_e;

   // XOR of data bits and parity bit for a correct frame
   localparam logic PAR_EVEN = 1'b0;

endpackage

// File: rtl/b_rx_obuf.sv
// One-entry valid/ready holding register for deserialised words.
// Load lands on out_valid next cycle; a load while full and not draining is dropped and flagged.
module b_rx_obuf #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic [DATA_W-1:0] load_data,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              loaded,
   output logic              ovf_evt
);

   logic drain;
   logic can_load;

   assign drain    = out_valid && out_ready;
   assign can_load = !out_valid || drain;
   assign loaded   = load && can_load;
   assign ovf_evt  = load && !can_load;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_data  <= '0;
         out_valid <= 1'b0;
      end else if (loaded) begin
         out_data  <= load_data;
         out_valid <= 1'b1;
      end else if (drain) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/b_rx_deser.sv
// Serial-to-word receiver: LSB-first frames of DATA_W data bits plus even parity.
// Word valid 1 clock after the parity bit; full output buffer drops new words and raises ovf.
module b_rx_deser
   import b_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_ser,
   input  logic              in_frm,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              par_err,
   output logic              frm_err,
   output logic              ovf,
   input  logic              err_clr,
   output logic [CNT_W-1:0]  frame_cnt
);

   localparam int BC_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
   localparam logic [BC_W-1:0] LAST_BIT = BC_W'(DATA_W - 1);

   b_state_e          state, state_nxt;
   logic [DATA_W-1:0] shreg;
   logic [BC_W-1:0]   bitcnt;
   logic              long_seen;

   logic start, shift, eval, frm_set, long_set;
   logic par_ok, load, loaded, ovf_evt;

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      start     = 1'b0;
      shift     = 1'b0;
      eval      = 1'b0;
      frm_set   = 1'b0;
      long_set  = 1'b0;
      case (state)
         IDLE: begin
            if (in_frm) begin
               start     = 1'b1;
               state_nxt = DATA;
            end
         end
         DATA: begin
            if (in_frm) begin
               shift = 1'b1;
               if (bitcnt == LAST_BIT) state_nxt = PAR;
            end else begin
               frm_set   = 1'b1;
               state_nxt = IDLE;
            end
         end
         PAR: begin
            if (in_frm) begin
               eval      = 1'b1;
               state_nxt = DRAIN;
            end else begin
               frm_set   = 1'b1;
               state_nxt = IDLE;
            end
         end
         DRAIN: begin
            if (!in_frm) begin
               state_nxt = IDLE;
            end else if (!long_seen) begin
               // flag an overlong frame once, even if err_clr fires while it persists
               frm_set  = 1'b1;
               long_set = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign par_ok = ((^shreg) ^ in_ser) == PAR_EVEN;
   assign load   = eval && par_ok;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         shreg     <= '0;
         bitcnt    <= '0;
         long_seen <= 1'b0;
         frame_cnt <= '0;
         par_err   <= 1'b0;
         frm_err   <= 1'b0;
         ovf       <= 1'b0;
      end else begin
         if (start) begin
            shreg  <= {{(DATA_W-1){1'b0}}, in_ser};
            bitcnt <= BC_W'(1);
         end else if (shift) begin
            shreg[bitcnt] <= in_ser;
            bitcnt        <= (bitcnt == LAST_BIT) ? '0 : bitcnt + BC_W'(1);
         end

         if (state != DRAIN) long_seen <= 1'b0;
         if (long_set)       long_seen <= 1'b1;

         if (loaded) frame_cnt <= frame_cnt + CNT_W'(1);

         // clear first so a same-cycle error still lands
         if (err_clr) begin
            par_err <= 1'b0;
            frm_err <= 1'b0;
            ovf     <= 1'b0;
         end
         if (eval && !par_ok) par_err <= 1'b1;
         if (frm_set)         frm_err <= 1'b1;
         if (ovf_evt)         ovf     <= 1'b1;
      end
   end

   b_rx_obuf #(.DATA_W(DATA_W)) u_obuf (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load),
      .load_data (shreg),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .loaded    (loaded),
      .ovf_evt   (ovf_evt)
   );

endmodule

// File: tb/tb_b_rx_deser.sv
// Directed bench for b_rx_deser: inputs driven and outputs sampled on the falling edge.
module tb_b_rx_deser;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_ser;
   logic        in_frm;
   logic [7:0]  out_data;
   logic        out_valid;
   logic        out_ready;
   logic        par_err;
   logic        frm_err;
   logic        ovf;
   logic        err_clr;
   logic [15:0] frame_cnt;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   b_rx_deser #(.DATA_W(8), .CNT_W(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_ser    (in_ser),
      .in_frm    (in_frm),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .par_err   (par_err),
      .frm_err   (frm_err),
      .ovf       (ovf),
      .err_clr   (err_clr),
      .frame_cnt (frame_cnt)
   );

   // After return, the parity cycle has been clocked and in_frm is low.
   task automatic send_frame(input logic [7:0] w, input logic p, input logic clr_at_par);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         in_frm = 1'b1;
         in_ser = w[i];
      end
      @(negedge clk);
      in_ser  = p;
      err_clr = clr_at_par;
      @(negedge clk);
      in_frm  = 1'b0;
      in_ser  = 1'b0;
      err_clr = 1'b0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; in_ser = 1'b0; in_frm = 1'b0; out_ready = 1'b0; err_clr = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({out_valid, par_err, frm_err, ovf} !== 4'b0000 || out_data !== 8'h00 || frame_cnt !== 16'd0) begin
         errors++;
         $display("FAIL reset: valid/par/frm/ovf=%b data=%h cnt=%0d, want 0000 00 0",
                  {out_valid, par_err, frm_err, ovf}, out_data, frame_cnt);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_basic;
      out_ready = 1'b1;
      send_frame(8'h05, 1'b0, 1'b0);
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'h05 || frame_cnt !== 16'd1) begin
         errors++;
         $display("FAIL basic_word: valid=%b data=%h cnt=%0d, want 1 05 1", out_valid, out_data, frame_cnt);
      end
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || {par_err, frm_err, ovf} !== 3'b000) begin
         errors++;
         $display("FAIL basic_accept: valid=%b flags=%b, want 0 000", out_valid, {par_err, frm_err, ovf});
      end
   endtask

   task automatic test_parity;
      send_frame(8'h07, 1'b0, 1'b0);
      checks++;
      if (par_err !== 1'b1 || out_valid !== 1'b0 || frame_cnt !== 16'd1) begin
         errors++;
         $display("FAIL parity_bad: par_err=%b valid=%b cnt=%0d, want 1 0 1", par_err, out_valid, frame_cnt);
      end
      @(negedge clk); err_clr = 1'b1;
      @(negedge clk); err_clr = 1'b0;
      checks++;
      if (par_err !== 1'b0) begin
         errors++;
         $display("FAIL parity_clear: par_err=%b, want 0", par_err);
      end
      send_frame(8'h07, 1'b0, 1'b1);
      checks++;
      if (par_err !== 1'b1) begin
         errors++;
         $display("FAIL parity_set_beats_clr: par_err=%b, want 1", par_err);
      end
      @(negedge clk); err_clr = 1'b1;
      @(negedge clk); err_clr = 1'b0;
   endtask

   task automatic test_ovf;
      out_ready = 1'b0;
      send_frame(8'h11, 1'b0, 1'b0);
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'h11 || frame_cnt !== 16'd2 || ovf !== 1'b0) begin
         errors++;
         $display("FAIL ovf_first: valid=%b data=%h cnt=%0d ovf=%b, want 1 11 2 0",
                  out_valid, out_data, frame_cnt, ovf);
      end
      send_frame(8'h22, 1'b0, 1'b0);
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'h11 || frame_cnt !== 16'd2 || ovf !== 1'b1) begin
         errors++;
         $display("FAIL ovf_drop: valid=%b data=%h cnt=%0d ovf=%b, want 1 11 2 1",
                  out_valid, out_data, frame_cnt, ovf);
      end
      out_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || frame_cnt !== 16'd2) begin
         errors++;
         $display("FAIL ovf_drain: valid=%b cnt=%0d, want 0 2", out_valid, frame_cnt);
      end
   endtask

   task automatic test_short_frame;
      logic [3:0] bits;
      bits = 4'b1011;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         in_frm = 1'b1;
         in_ser = bits[i];
      end
      @(negedge clk); in_frm = 1'b0; in_ser = 1'b0;
      @(negedge clk);
      checks++;
      if (frm_err !== 1'b1 || out_valid !== 1'b0 || frame_cnt !== 16'd2) begin
         errors++;
         $display("FAIL short_frame: frm_err=%b valid=%b cnt=%0d, want 1 0 2", frm_err, out_valid, frame_cnt);
      end
      send_frame(8'h3C, 1'b0, 1'b0);
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'h3C || frame_cnt !== 16'd3 || par_err !== 1'b0) begin
         errors++;
         $display("FAIL after_short: valid=%b data=%h cnt=%0d par_err=%b, want 1 3c 3 0",
                  out_valid, out_data, frame_cnt, par_err);
      end
      @(negedge clk); err_clr = 1'b1;
      @(negedge clk); err_clr = 1'b0;
      checks++;
      if ({par_err, frm_err, ovf} !== 3'b000) begin
         errors++;
         $display("FAIL clear_all: flags=%b, want 000", {par_err, frm_err, ovf});
      end
   endtask

   task automatic test_overlong;
      logic [7:0] w;
      w = 8'h81;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         in_frm = 1'b1;
         in_ser = w[i];
      end
      @(negedge clk); in_ser = 1'b0;
      @(negedge clk); in_ser = 1'b1;
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'h81 || frame_cnt !== 16'd4 || frm_err !== 1'b0) begin
         errors++;
         $display("FAIL overlong_word: valid=%b data=%h cnt=%0d frm_err=%b, want 1 81 4 0",
                  out_valid, out_data, frame_cnt, frm_err);
      end
      @(negedge clk);
      checks++;
      if (frm_err !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL overlong_flag: frm_err=%b valid=%b, want 1 0", frm_err, out_valid);
      end
      err_clr = 1'b1;
      @(negedge clk); err_clr = 1'b0;
      @(negedge clk); in_frm = 1'b0; in_ser = 1'b0;
      checks++;
      if (frm_err !== 1'b0 || out_valid !== 1'b0 || frame_cnt !== 16'd4) begin
         errors++;
         $display("FAIL overlong_once: frm_err=%b valid=%b cnt=%0d, want 0 0 4", frm_err, out_valid, frame_cnt);
      end
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || frame_cnt !== 16'd4) begin
         errors++;
         $display("FAIL overlong_no_second: valid=%b cnt=%0d, want 0 4", out_valid, frame_cnt);
      end
   endtask

   task automatic test_reset_mid_frame;
      logic [7:0] w;
      send_frame(8'h01, 1'b0, 1'b0);
      checks++;
      if (par_err !== 1'b1) begin
         errors++;
         $display("FAIL pre_reset_par: par_err=%b, want 1", par_err);
      end
      w = 8'hA5;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         in_frm = 1'b1;
         in_ser = w[i];
         if (i == 5) rst_n = 1'b0;
      end
      @(negedge clk); rst_n = 1'b1; in_frm = 1'b0; in_ser = 1'b0;
      checks++;
      if ({out_valid, par_err, frm_err, ovf} !== 4'b0000 || out_data !== 8'h00 || frame_cnt !== 16'd0) begin
         errors++;
         $display("FAIL mid_reset: valid/par/frm/ovf=%b data=%h cnt=%0d, want 0000 00 0",
                  {out_valid, par_err, frm_err, ovf}, out_data, frame_cnt);
      end
      send_frame(8'hA5, 1'b0, 1'b0);
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'hA5 || frame_cnt !== 16'd1 || {par_err, frm_err} !== 2'b00) begin
         errors++;
         $display("FAIL after_reset: valid=%b data=%h cnt=%0d flags=%b, want 1 a5 1 00",
                  out_valid, out_data, frame_cnt, {par_err, frm_err});
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_parity();
      test_ovf();
      test_short_frame();
      test_overlong();
      test_reset_mid_frame();
      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
